// File: rtl/freelist_ctrl.sv
// Physical-register free list / 3-wide allocator with retire reclaim and one-cycle mispredict recovery.
// Define FREELIST_DISP_EN for display ports and simulation assertions.
module freelist_ctrl #(
  parameter int NUM_PR = 64,
  parameter int PR_W = $clog2(NUM_PR),
  localparam int DEPTH = NUM_PR - 32,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           dispatch_req,
  output logic [2:0][PR_W-1:0] new_pr,
  output logic [2:0]           new_pr_valid,
  output logic [PR_W:0]        free_count,
  input  logic [2:0]           retire_valid,
  input  logic [2:0][PR_W-1:0] retire_told,
  input  logic                 BPRecoverEN,
  output logic                 overflow_err
`ifdef FREELIST_DISP_EN
  ,
  output logic [PR_W-1:0]      fl_disp [DEPTH],
  output logic [PW-1:0]        head_disp,
  output logic [PW-1:0]        tail_disp
`endif
);

  localparam int WW = PR_W + 2;

  logic [PR_W-1:0] fl_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PR_W:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic [2:0]      gnt;
  logic [2:0]      we;
  logic [2:0][PW-1:0] wa;
  logic [WW-1:0]   g, n, room, sum;
  int              off, wcnt;

  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p,
                                         input int k);
    int s;
    s = int'(p) + k;
    return PW'(s % DEPTH);
  endfunction

  // Lanes are served oldest first (2,1,0) from consecutive head slots.
  always_comb begin
    off = 0;
    gnt = '0;
    for (int i = 2; i >= 0; i--) begin
      new_pr[i] = fl_q[wrap(head_q, off)];
      if (dispatch_req[i]) begin
        if (WW'(off) < WW'(cnt_q)) gnt[i] = 1'b1;
        off = off + 1;
      end
    end
  end

  assign new_pr_valid = gnt & {3{~BPRecoverEN}};

  always_comb begin
    g = WW'(new_pr_valid[0]) + WW'(new_pr_valid[1])
      + WW'(new_pr_valid[2]);
    n = WW'(retire_valid[0]) + WW'(retire_valid[1])
      + WW'(retire_valid[2]);
    room = WW'(DEPTH) - WW'(cnt_q) + g;
    sum = WW'(cnt_q) - g + n;
    wcnt = 0;
    we = '0;
    wa = '0;
    for (int i = 2; i >= 0; i--) begin
      wa[i] = wrap(tail_q, wcnt);
      if (retire_valid[i] && WW'(wcnt) < room) begin
        we[i] = 1'b1;
        wcnt = wcnt + 1;
      end
    end
    tail_d = wrap(tail_q, wcnt);
    ovf_d = ovf_q | (sum > WW'(DEPTH));
    if (BPRecoverEN) begin
      head_d = tail_d;
      cnt_d = (PR_W+1)'(DEPTH);
    end else begin
      head_d = wrap(head_q, int'(g));
      cnt_d = (sum > WW'(DEPTH)) ? (PR_W+1)'(DEPTH)
                                 : (PR_W+1)'(sum);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) fl_q[k] <= PR_W'(32 + k);
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= (PR_W+1)'(DEPTH);
      ovf_q <= 1'b0;
    end else begin
      for (int i = 2; i >= 0; i--)
        if (we[i]) fl_q[wa[i]] <= retire_told[i];
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign free_count = cnt_q;
  assign overflow_err = ovf_q;

`ifdef FREELIST_DISP_EN
  logic ident_q;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) fl_disp[k] = fl_q[k];
  end
  assign head_disp = head_q;
  assign tail_disp = tail_q;

  // Map stays identity until the first allocation after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ident_q <= 1'b1;
    else if (g != '0) ident_q <= 1'b0;
  end

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        if (retire_valid[i]) begin
          if (ident_q)
            assert (int'(retire_told[i]) >= 32)
              else $error("arch tag %0d retired", retire_told[i]);
          for (int k = 0; k < DEPTH; k++)
            if (k < int'(cnt_q))
              assert (fl_q[wrap(head_q, k)] != retire_told[i])
                else $error("tag %0d already free", retire_told[i]);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_freelist_ctrl.sv
// Scoreboard bench for freelist_ctrl: driver queues hand-computed expectations,
// negedge monitor pops and compares.
module tb_freelist_ctrl;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [2:0]       dispatch_req = '0;
  logic [2:0][5:0]  new_pr;
  logic [2:0]       new_pr_valid;
  logic [6:0]       free_count;
  logic [2:0]       retire_valid = '0;
  logic [2:0][5:0]  retire_told = '0;
  logic             BPRecoverEN = 1'b0;
  logic             overflow_err;

  typedef struct {
    logic [2:0]      vld;
    logic [2:0][5:0] pr;
    logic [2:0]      msk;
    logic [6:0]      cnt;
    logic            ovf;
    int              id;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   vid = 0;

  freelist_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .dispatch_req (dispatch_req),
    .new_pr       (new_pr),
    .new_pr_valid (new_pr_valid),
    .free_count   (free_count),
    .retire_valid (retire_valid),
    .retire_told  (retire_told),
    .BPRecoverEN  (BPRecoverEN),
    .overflow_err (overflow_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input int id,
                       input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL v%0d %s: got %0d expected %0d", id, nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("valid", e.id, int'(new_pr_valid), int'(e.vld));
      check("free_count", e.id, int'(free_count), int'(e.cnt));
      check("overflow", e.id, int'(overflow_err), int'(e.ovf));
      for (int i = 0; i < 3; i++)
        if (e.msk[i])
          check($sformatf("new_pr[%0d]", i), e.id,
                int'(new_pr[i]), int'(e.pr[i]));
    end
  end

  task automatic push(input logic [2:0] ev, input int p2, input int p1,
                      input int p0, input logic [2:0] m, input int c,
                      input logic o);
    exp_t e;
    e.vld = ev;
    e.pr[2] = 6'(p2);
    e.pr[1] = 6'(p1);
    e.pr[0] = 6'(p0);
    e.msk = m;
    e.cnt = 7'(c);
    e.ovf = o;
    e.id = vid;
    vid++;
    q.push_back(e);
  endtask

  task automatic vec(input logic [2:0] req, input logic [2:0] rv,
                     input int t2, input int t1, input int t0,
                     input logic rec, input logic [2:0] ev,
                     input int p2, input int p1, input int p0,
                     input logic [2:0] m, input int c, input logic o);
    @(posedge clock);
    #1;
    reset = 1'b1;
    dispatch_req = req;
    retire_valid = rv;
    retire_told[2] = 6'(t2);
    retire_told[1] = 6'(t1);
    retire_told[0] = 6'(t0);
    BPRecoverEN = rec;
    push(ev, p2, p1, p0, m, c, o);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    dispatch_req = '0;
    retire_valid = '0;
    BPRecoverEN = 1'b0;
    push(3'b000, 0, 0, 0, 3'b000, 32, 1'b0);
  endtask

  initial begin
    // 3-wide grant from reset
    do_reset();
    vec(3'b111, 3'b000, 0, 0, 0, 0, 3'b111, 32, 33, 34, 3'b111, 32, 0);
    vec(3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 29, 0);

    // Sparse request 101, then drain to two entries
    do_reset();
    vec(3'b101, 3'b000, 0, 0, 0, 0, 3'b101, 32, 0, 33, 3'b101, 32, 0);
    vec(3'b100, 3'b000, 0, 0, 0, 0, 3'b100, 34, 0, 0, 3'b100, 30, 0);
    for (int i = 0; i < 9; i++)
      vec(3'b111, 3'b000, 0, 0, 0, 0, 3'b111,
          35 + 3 * i, 36 + 3 * i, 37 + 3 * i, 3'b111, 29 - 3 * i, 0);
    vec(3'b111, 3'b000, 0, 0, 0, 0, 3'b110, 62, 63, 0, 3'b110, 2, 0);
    vec(3'b111, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0);

    // Refill five slots, reallocate them: head = tail = 5, empty
    vec(3'b000, 3'b111, 0, 1, 2, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
    vec(3'b000, 3'b110, 3, 4, 0, 0, 3'b000, 0, 0, 0, 3'b000, 3, 0);
    vec(3'b111, 3'b000, 0, 0, 0, 0, 3'b111, 0, 1, 2, 3'b111, 5, 0);
    vec(3'b110, 3'b000, 0, 0, 0, 0, 3'b110, 3, 4, 0, 3'b110, 2, 0);
    // Retire 7,9 while empty: no same-cycle bypass
    vec(3'b111, 3'b110, 7, 9, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
    vec(3'b100, 3'b000, 0, 0, 0, 0, 3'b100, 7, 0, 0, 3'b100, 2, 0);
    vec(3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 1, 0);

    // Recovery after 10 allocations
    do_reset();
    vec(3'b111, 3'b000, 0, 0, 0, 0, 3'b111, 32, 33, 34, 3'b111, 32, 0);
    vec(3'b111, 3'b000, 0, 0, 0, 0, 3'b111, 35, 36, 37, 3'b111, 29, 0);
    vec(3'b111, 3'b000, 0, 0, 0, 0, 3'b111, 38, 39, 40, 3'b111, 26, 0);
    vec(3'b100, 3'b000, 0, 0, 0, 0, 3'b100, 41, 0, 0, 3'b100, 23, 0);
    vec(3'b111, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 3'b000, 22, 0);
    vec(3'b111, 3'b000, 0, 0, 0, 0, 3'b111, 32, 33, 34, 3'b111, 32, 0);

    // Overflow: retire into a full list, sticky until reset
    do_reset();
    vec(3'b000, 3'b100, 5, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 32, 0);
    vec(3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 32, 1);
    vec(3'b100, 3'b000, 0, 0, 0, 0, 3'b100, 32, 0, 0, 3'b100, 32, 1);
    vec(3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 31, 1);
    do_reset();
    vec(3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 32, 0);

    repeat (2) @(negedge clock);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
